// File: rtl/ext_link_if.sv
// On-chip side of the serial link controller: TX request/ack and RX FIFO ports.
interface ext_link_if #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned COUNT_WIDTH = 3
);
   logic [DATA_WIDTH-1:0]  tx_data;
   logic                   tx_valid;
   logic                   tx_ready;
   logic                   tx_done;
   logic                   tx_err;
   logic [DATA_WIDTH-1:0]  rx_data;
   logic                   rx_valid;
   logic                   rx_ready;
   logic [COUNT_WIDTH-1:0] rx_count;
   logic                   rx_overflow;
   logic                   rx_err;

   // On-chip logic that sends words and drains the RX FIFO
   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, tx_done, tx_err, rx_data, rx_valid, rx_count, rx_overflow, rx_err
   );

   // The link controller itself
   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, tx_done, tx_err, rx_data, rx_valid, rx_count, rx_overflow, rx_err
   );
endinterface

// File: rtl/ext_link_ctrl.sv
// External serial link controller: auto-baud sync, acked framed RX into a FIFO, acked framed TX.
module ext_link_ctrl #(
   parameter int unsigned            DATA_WIDTH     = 8,
   parameter int unsigned            PREFIX_WIDTH   = 2,
   parameter logic [PREFIX_WIDTH-1:0] RX_PREFIX     = '0,
   parameter logic [PREFIX_WIDTH-1:0] TX_PREFIX     = '0,
   parameter int unsigned            FIFO_DEPTH     = 4,
   parameter int unsigned            DEFAULT_BAUD   = 16,
   parameter int unsigned            MIN_BAUD       = 4,
   parameter int unsigned            MAX_BAUD       = 4096,
   parameter int unsigned            TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic        tx,
   output logic [15:0] baud_size,
   output logic        busy,
   ext_link_if.slave   link
);
   localparam int unsigned NB = PREFIX_WIDTH + DATA_WIDTH;
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = 16;
   localparam int unsigned IW = $clog2(NB + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_SYNC_ERR, S_ACK1, S_WAIT_START, S_RX_BITS, S_ACK2,
      S_TX_SYNC, S_TX_WACK, S_TX_BITS, S_TX_FACK
   } state_t;

   state_t          state, state_nxt;
   logic            rx_s1, rxs;
   logic [BW-1:0]   cnt, cnt_nxt, tmo, tmo_nxt, baud_q, baud_nxt;
   logic [IW-1:0]   bit_idx, bit_idx_nxt;
   logic [1:0]      phase, phase_nxt;
   logic [NB-1:0]   rx_sh, rx_sh_nxt;
   logic [NB:0]     tx_sh, tx_sh_nxt;
   logic            tx_q, tx_nxt;
   logic            tx_done_q, tx_done_nxt, tx_err_q, tx_err_nxt, rx_err_q, rx_err_nxt;
   logic            push_c, pop_c, ovf_set_c, full_c;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  overflow;

   function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
      return (v == '1) ? v : v + BW'(1);
   endfunction

   assign full_c = (count == CW'(FIFO_DEPTH));
   assign pop_c  = link.rx_ready && (count != '0);

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rxs   <= rx_s1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state, bit timing, shift registers and pulse generation
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tmo_nxt     = tmo;
      baud_nxt    = baud_q;
      bit_idx_nxt = bit_idx;
      phase_nxt   = phase;
      rx_sh_nxt   = rx_sh;
      tx_sh_nxt   = tx_sh;
      tx_nxt      = tx_q;
      tx_done_nxt = 1'b0;
      tx_err_nxt  = 1'b0;
      rx_err_nxt  = 1'b0;
      push_c      = 1'b0;
      ovf_set_c   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!rxs) begin
               state_nxt = S_SYNC;
               cnt_nxt   = BW'(1);
            end else if (link.tx_valid) begin
               state_nxt = S_TX_SYNC;
               tx_nxt    = 1'b0;
               cnt_nxt   = BW'(1);
               tx_sh_nxt = {1'b1, link.tx_data, TX_PREFIX};
            end
         end
         S_SYNC: begin
            if (!rxs) begin
               if (cnt >= BW'(MAX_BAUD)) begin
                  rx_err_nxt = 1'b1;
                  state_nxt  = S_SYNC_ERR;
               end else begin
                  cnt_nxt = sat_inc(cnt);
               end
            end else if (cnt < BW'(MIN_BAUD)) begin
               state_nxt = S_IDLE;
            end else begin
               baud_nxt  = cnt;
               state_nxt = S_ACK1;
               tx_nxt    = 1'b0;
               cnt_nxt   = BW'(1);
            end
         end
         S_SYNC_ERR: begin
            if (rxs) state_nxt = S_IDLE;
         end
         S_ACK1: begin
            if (cnt >= baud_q) begin
               tx_nxt    = 1'b1;
               state_nxt = S_WAIT_START;
               tmo_nxt   = '0;
               phase_nxt = 2'd0;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_WAIT_START: begin
            tmo_nxt = sat_inc(tmo);
            if (tmo >= BW'(TIMEOUT_CYCLES - 1)) begin
               rx_err_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else if (phase == 2'd0) begin
               if (!rxs) begin
                  phase_nxt = 2'd1;
                  cnt_nxt   = BW'(1);
               end
            end else if (cnt >= (baud_q >> 1)) begin
               if (!rxs) begin
                  state_nxt   = S_RX_BITS;
                  cnt_nxt     = BW'(1);
                  bit_idx_nxt = '0;
               end else begin
                  phase_nxt = 2'd0;
               end
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_RX_BITS: begin
            if (cnt >= baud_q) begin
               cnt_nxt = BW'(1);
               if (bit_idx == IW'(NB)) begin
                  state_nxt = S_IDLE;
                  if (!rxs || (rx_sh[PREFIX_WIDTH-1:0] != RX_PREFIX)) begin
                     rx_err_nxt = 1'b1;
                  end else if (full_c) begin
                     ovf_set_c = 1'b1;
                  end else begin
                     push_c    = 1'b1;
                     state_nxt = S_ACK2;
                     tx_nxt    = 1'b0;
                  end
               end else begin
                  rx_sh_nxt   = {rxs, rx_sh[NB-1:1]};
                  bit_idx_nxt = bit_idx + IW'(1);
               end
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_ACK2: begin
            if (cnt >= baud_q) begin
               tx_nxt    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_TX_SYNC: begin
            if (cnt >= baud_q) begin
               tx_nxt    = 1'b1;
               state_nxt = S_TX_WACK;
               tmo_nxt   = '0;
               phase_nxt = 2'd0;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_TX_WACK: begin
            tmo_nxt = sat_inc(tmo);
            if ((phase != 2'd2) && (tmo >= BW'(TIMEOUT_CYCLES - 1))) begin
               tx_err_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else if (phase == 2'd0) begin
               if (!rxs) phase_nxt = 2'd1;
            end else if (phase == 2'd1) begin
               if (rxs) begin
                  phase_nxt = 2'd2;
                  cnt_nxt   = BW'(1);
               end
            end else if (cnt >= baud_q) begin
               state_nxt   = S_TX_BITS;
               tx_nxt      = 1'b0;
               cnt_nxt     = BW'(1);
               bit_idx_nxt = '0;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_TX_BITS: begin
            if (cnt >= baud_q) begin
               cnt_nxt = BW'(1);
               if (bit_idx == IW'(NB + 1)) begin
                  state_nxt = S_TX_FACK;
                  tmo_nxt   = '0;
                  phase_nxt = 2'd0;
               end else begin
                  tx_nxt      = tx_sh[0];
                  tx_sh_nxt   = {1'b0, tx_sh[NB:1]};
                  bit_idx_nxt = bit_idx + IW'(1);
               end
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         S_TX_FACK: begin
            tmo_nxt = sat_inc(tmo);
            if (tmo >= BW'(TIMEOUT_CYCLES - 1)) begin
               tx_err_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else if (phase == 2'd0) begin
               if (!rxs) phase_nxt = 2'd1;
            end else if (rxs) begin
               tx_done_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers; reset forces the line idle high
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         tmo       <= '0;
         baud_q    <= BW'(DEFAULT_BAUD);
         bit_idx   <= '0;
         phase     <= 2'd0;
         rx_sh     <= '0;
         tx_sh     <= '0;
         tx_q      <= 1'b1;
         tx_done_q <= 1'b0;
         tx_err_q  <= 1'b0;
         rx_err_q  <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         tmo       <= tmo_nxt;
         baud_q    <= baud_nxt;
         bit_idx   <= bit_idx_nxt;
         phase     <= phase_nxt;
         rx_sh     <= rx_sh_nxt;
         tx_sh     <= tx_sh_nxt;
         tx_q      <= tx_nxt;
         tx_done_q <= tx_done_nxt;
         tx_err_q  <= tx_err_nxt;
         rx_err_q  <= rx_err_nxt;
      end
   end

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= rx_sh[NB-1:PREFIX_WIDTH];
   end

   // RX FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_c)    wr_ptr   <= wr_ptr + AW'(1);
         if (pop_c)     rd_ptr   <= rd_ptr + AW'(1);
         if (ovf_set_c) overflow <= 1'b1;
         unique case ({push_c, pop_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign tx               = tx_q;
   assign baud_size        = baud_q;
   assign busy             = (state != S_IDLE);
   assign link.tx_ready    = (state == S_IDLE) && rxs;
   assign link.tx_done     = tx_done_q;
   assign link.tx_err      = tx_err_q;
   assign link.rx_err      = rx_err_q;
   assign link.rx_data     = mem[rd_ptr];
   assign link.rx_valid    = (count != '0);
   assign link.rx_count    = count;
   assign link.rx_overflow = overflow;
endmodule
